matrix_scan_capture: RTL and testbench
======================================

Name: matrix_scan_capture

Overview:
Receive-side counterpart of the 8x8 LED scan display. It samples the multiplexed column/row drive lines and debounces each row strobe. It rebuilds the full gs*gs frame bitmap and hands completed frames to a consumer over a valid/ready handshake. Uses: loopback self-check of the display path, or as the frame input of a second board that mirrors the game screen.

Parameters:
GS, 8, matrix edge length; frame width is GS*GS bits.
STABLE_CYC, 4, consecutive identical samples required before a row is accepted (≥1).
COL_INV, 0, 1 = column lines are active-low and are inverted before storage.

Ports:
clk_i  input  1  system clock; all logic on rising edge.
rst_n  input  1  asynchronous active-low reset.
col_val_i  input  GS  column (pixel) lines of the currently strobed row.
row_val_i  input  GS  row strobe lines, active-high; valid when exactly one bit is set.
clear_i  input  1  synchronous clear of the partial frame and overrun flag.
frame_o  output  GS*GS  last published frame; row r occupies bits [r*GS +: GS], column c is bit c of that slice.
frame_valid_o  output  1  frame_o holds an unconsumed frame.
frame_ready_i  input  1  consumer accepts frame_o when high with frame_valid_o.
overrun_o  output  1  sticky: a frame completed while the previous frame was still unconsumed.
row_err_o  output  1  one-cycle pulse when row_val_i sampled with more than one bit set.

Behaviour:
- Reset (async, rst_n=0): frame_o=0, frame_valid_o=0, overrun_o=0, row_err_o=0, row buffer=0, seen mask=0, stability counter=0, FSM=WAIT.
- Sample stage: row_s/col_s registered from the inputs every edge. col_s is inverted when COL_INV=1. All decisions use the registered samples.
- FSM WAIT: row_s is one-hot -> load prev_row/prev_col, cnt=1, go to SETTLE. row_s=0 -> stay. Multi-hot -> row_err_o pulse, stay.
- FSM SETTLE: row_s==prev_row and col_s==prev_col -> cnt+1. On the edge where cnt reaches STABLE_CYC, accept the row, then go to HOLD. Any mismatch -> treat the sample as in WAIT; a one-hot sample restarts the count at 1. Multi-hot -> row_err_o pulse, go to WAIT.
- Accept: buffer slot idx(row_s) <= col_s and seen[idx] <= 1, both on the accepting edge. A row already seen is overwritten with the newer value.
- FSM HOLD: stay while row_s==prev_row. On any change, re-evaluate the sample as in WAIT on that edge. A column change within the same row is ignored until the row changes.
- STABLE_CYC=1: accept on the first one-hot sample, skipping SETTLE.
- Frame complete: when an accept makes seen all-ones, then on the same edge:
  - if frame_valid_o=0 or frame_ready_i=1: frame_o <= buffer including the new row, frame_valid_o <= 1.
  - otherwise: frame_o unchanged, overrun_o <= 1.
  - In both cases seen <= 0; buffer contents are retained.
- Handshake: frame_valid_o && frame_ready_i at an edge consumes the frame, and frame_valid_o falls next cycle. Exception: if a new frame publishes on that same edge, frame_valid_o stays 1 with the new data. frame_o is stable while valid is high and unconsumed.
- Latency: input change to accept is STABLE_CYC+1 edges (1 sample + STABLE_CYC compares). Accepting the last row to frame_valid_o=1 is 0 extra edges.
- clear_i: seen <= 0, overrun_o <= 0, FSM <= WAIT. frame_o and frame_valid_o untouched. clear_i has priority over an accept on the same edge.
- row_err_o is registered, exactly one cycle per offending sample.

Optional Feature:
SCAN_SYNC_EN: when defined, row_val_i and col_val_i pass through a 2-flop synchronizer before the sample stage. This adds 2 edges to all latencies, for use when the scan lines come from another board. When undefined, inputs go straight into the sample stage, since the source is in the clk_i domain.

Test Plan:
- Reset, then strobe rows 0..7 one-hot, each held 6 cycles, col=row index+1, ready=1 -> frame_valid_o rises on the accept of row 7; frame_o[r*8 +: 8]==r+1 for all r.
- Row 3 held only 3 cycles (STABLE_CYC=4), then row 4 -> slot 3 not written, seen[3]=0; row 3 then held 5 cycles -> accepted.
- row_val_i=8'b0001_0100 for 2 cycles -> row_err_o pulses twice, FSM stays WAIT, no slot written.
- Frame A published, ready=0, full frame B scanned -> overrun_o=1, frame_o==A. Then clear_i=1 for 1 cycle -> overrun_o=0, frame_valid_o still 1.
- ready=1 on the same edge frame C completes while frame A is valid -> frame_valid_o stays 1, frame_o==C, overrun_o=0.
- rst_n low mid-frame after 5 rows -> all outputs 0 immediately. A fresh 8-row scan is needed to raise frame_valid_o.

Source files
------------

// File: rtl/matrix_scan_capture.sv
// Rebuilds GS x GS frames from a multiplexed row/column scan, debounces each row strobe
// and publishes completed frames over valid/ready. Define SCAN_SYNC_EN to add 2-flop input synchronizers.
module matrix_scan_capture #(
    parameter int unsigned GS         = 8,
    parameter int unsigned STABLE_CYC = 4,
    parameter bit          COL_INV    = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_n,
    input  logic [GS-1:0]    col_val_i,
    input  logic [GS-1:0]    row_val_i,
    input  logic             clear_i,
    output logic [GS*GS-1:0] frame_o,
    output logic             frame_valid_o,
    input  logic             frame_ready_i,
    output logic             overrun_o,
    output logic             row_err_o
);
    localparam int unsigned   CW       = (STABLE_CYC < 2) ? 1 : $clog2(STABLE_CYC);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYC - 1);

    typedef enum logic [1:0] {S_WAIT, S_SETTLE, S_HOLD} state_e;

    logic [GS-1:0] row_in, col_in;

`ifdef SCAN_SYNC_EN
    logic [GS-1:0] row_m1_q, row_m2_q, col_m1_q, col_m2_q;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            row_m1_q <= '0;
            row_m2_q <= '0;
            col_m1_q <= '0;
            col_m2_q <= '0;
        end else begin
            row_m1_q <= row_val_i;
            row_m2_q <= row_m1_q;
            col_m1_q <= col_val_i;
            col_m2_q <= col_m1_q;
        end
    end

    assign row_in = row_m2_q;
    assign col_in = col_m2_q;
`else
    assign row_in = row_val_i;
    assign col_in = col_val_i;
`endif

    state_e           state_q, state_d, fresh_state;
    logic [GS-1:0]    row_s_q, col_s_q;
    logic [GS-1:0]    prev_row_q, prev_col_q;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [GS*GS-1:0] buf_q, buf_d;
    logic [GS-1:0]    seen_q, seen_d;
    logic [GS*GS-1:0] frame_q;
    logic             valid_q, overrun_q, row_err_q;
    logic             one_hot, multi_hot, same_row, match;
    logic             restart, accept, fresh_accept, complete, publish;

    always_comb begin
        multi_hot = (row_s_q & (row_s_q - GS'(1))) != '0;
        one_hot   = (row_s_q != '0) && !multi_hot;
        same_row  = row_s_q == prev_row_q;
        match     = same_row && (col_s_q == prev_col_q);

        buf_d = buf_q;
        for (int unsigned r = 0; r < GS; r++) begin
            if (row_s_q[r]) buf_d[r*GS +: GS] = col_s_q;
        end
        seen_d = seen_q | row_s_q;

        // Any sample that breaks a settle/hold run is re-evaluated as if idle on the same edge
        fresh_state  = one_hot ? ((STABLE_CYC <= 1) ? S_HOLD : S_SETTLE) : S_WAIT;
        fresh_accept = one_hot && (STABLE_CYC <= 1);

        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        restart = 1'b0;
        unique case (state_q)
            S_SETTLE: begin
                if (match) begin
                    if (cnt_q == CNT_LAST) begin
                        accept  = 1'b1;
                        state_d = S_HOLD;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else begin
                    restart = 1'b1;
                end
            end
            S_HOLD:  restart = !same_row;
            default: restart = 1'b1;
        endcase
        if (restart) begin
            state_d = fresh_state;
            accept  = fresh_accept;
            cnt_d   = CW'(1);
        end

        complete = accept && (&seen_d);
        publish  = complete && (!valid_q || frame_ready_i);
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_WAIT;
            row_s_q    <= '0;
            col_s_q    <= '0;
            prev_row_q <= '0;
            prev_col_q <= '0;
            cnt_q      <= '0;
            buf_q      <= '0;
            seen_q     <= '0;
            frame_q    <= '0;
            valid_q    <= 1'b0;
            overrun_q  <= 1'b0;
            row_err_q  <= 1'b0;
        end else begin
            row_s_q   <= row_in;
            col_s_q   <= COL_INV ? ~col_in : col_in;
            row_err_q <= multi_hot;

            if (clear_i) begin
                state_q   <= S_WAIT;
                seen_q    <= '0;
                overrun_q <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                if (restart && one_hot) begin
                    prev_row_q <= row_s_q;
                    prev_col_q <= col_s_q;
                end
                if (accept) begin
                    buf_q  <= buf_d;
                    seen_q <= complete ? '0 : seen_d;
                end
                if (complete && !publish) overrun_q <= 1'b1;
            end

            if (publish && !clear_i) begin
                frame_q <= buf_d;
                valid_q <= 1'b1;
            end else if (frame_ready_i) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign frame_o       = frame_q;
    assign frame_valid_o = valid_q;
    assign overrun_o     = overrun_q;
    assign row_err_o     = row_err_q;

endmodule

// File: tb/tb_matrix_scan_capture.sv
// Self-checking bench for matrix_scan_capture: directed vector table, hand-written corner
// sequences and randomized scans compared every cycle against a sample-window reference model.
module tb_matrix_scan_capture;
    localparam int unsigned GS     = 8;
    localparam int unsigned STABLE = 4;

    logic            clk_i, rst_n, clear_i, frame_ready_i;
    logic [GS-1:0]   col_val_i, row_val_i;
    logic [GS*GS-1:0] frame_o;
    logic            frame_valid_o, overrun_o, row_err_o;

    matrix_scan_capture #(.GS(GS), .STABLE_CYC(STABLE), .COL_INV(1'b0)) dut (
        .clk_i(clk_i), .rst_n(rst_n), .col_val_i(col_val_i), .row_val_i(row_val_i),
        .clear_i(clear_i), .frame_o(frame_o), .frame_valid_o(frame_valid_o),
        .frame_ready_i(frame_ready_i), .overrun_o(overrun_o), .row_err_o(row_err_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference model: a row is accepted when the last STABLE samples are identical and
    // one-hot, unless that row was already accepted and has not been released since.
    logic [15:0]      hist[$];
    logic [7:0]       m_srow, m_scol, m_lock_row;
    bit               m_locked;
    logic [7:0]       m_buf[GS];
    bit   [GS-1:0]    m_seen;
    logic [GS*GS-1:0] m_frame;
    bit               m_valid, m_over, m_err;

    task automatic model_reset();
        hist.delete();
        m_srow = '0; m_scol = '0; m_lock_row = '0; m_locked = 0;
        foreach (m_buf[i]) m_buf[i] = '0;
        m_seen = '0; m_frame = '0; m_valid = 0; m_over = 0; m_err = 0;
    endtask

    task automatic model_edge();
        bit acc, pub, consume;
        acc = 0; pub = 0;
        consume = m_valid && frame_ready_i;
        if (clear_i) begin
            hist.delete();
            m_locked = 0;
            m_seen = '0;
            m_over = 0;
        end else if (!(m_locked && m_srow == m_lock_row)) begin
            m_locked = 0;
            hist.push_back({m_srow, m_scol});
            if (hist.size() > STABLE) void'(hist.pop_front());
            if ($countones(m_srow) == 1 && hist.size() == STABLE) begin
                acc = 1;
                foreach (hist[i]) if (hist[i] != hist[0]) acc = 0;
            end
        end
        if (acc) begin
            m_locked = 1;
            m_lock_row = m_srow;
            for (int i = 0; i < GS; i++) if (m_srow[i]) begin
                m_buf[i] = m_scol;
                m_seen[i] = 1;
            end
            if (&m_seen) begin
                if (!m_valid || frame_ready_i) begin
                    pub = 1;
                    for (int i = 0; i < GS; i++) m_frame[i*GS +: GS] = m_buf[i];
                end else begin
                    m_over = 1;
                end
                m_seen = '0;
            end
        end
        if (pub) m_valid = 1;
        else if (consume) m_valid = 0;
        m_err  = $countones(m_srow) > 1;
        m_srow = row_val_i;
        m_scol = col_val_i;
    endtask

    task automatic step();
        model_edge();
        @(posedge clk_i);
        #1;
        check("model", {frame_o, frame_valid_o, overrun_o, row_err_o},
              {m_frame, m_valid, m_over, m_err});
    endtask

    task automatic scan_row(input int r, input logic [7:0] col, input int hold, input bit rdy);
        row_val_i = 8'(1 << r);
        col_val_i = col;
        frame_ready_i = rdy;
        clear_i = 1'b0;
        repeat (hold) step();
    endtask

    typedef struct {
        logic [7:0]  row;
        logic [7:0]  col;
        int          hold;
        bit          ready;
        bit          clear;
        bit          exp_valid;
        bit          exp_over;
        bit          chk_frame;
        logic [63:0] exp_frame;
    } vec_t;

    function automatic vec_t mk(logic [7:0] row, logic [7:0] col, int hold, bit ready, bit clear,
                                bit ev, bit eo, bit cf, logic [63:0] ef);
        vec_t v;
        v.row = row; v.col = col; v.hold = hold; v.ready = ready; v.clear = clear;
        v.exp_valid = ev; v.exp_over = eo; v.chk_frame = cf; v.exp_frame = ef;
        return v;
    endfunction

    localparam logic [63:0] FRAME_1 = 64'h0807_0605_0403_0201;
    localparam logic [63:0] FRAME_A = 64'h1716_1514_3512_1110;
    localparam logic [63:0] FRAME_C = 64'h4746_4544_4342_4140;
    localparam logic [63:0] FRAME_R = 64'h6766_6564_6362_6160;

    vec_t vecs[$];
    int   err_pulses;
    int   rows_b[6] = '{0, 1, 2, 5, 6, 7};

    initial begin
        rst_n = 1'b0; clear_i = 1'b0; frame_ready_i = 1'b0;
        row_val_i = '0; col_val_i = '0;
        model_reset();

        // Full scan with ready high, row 7 held exactly up to its accepting edge
        for (int r = 0; r < 8; r++)
            vecs.push_back(mk(8'(1 << r), 8'(r + 1), (r == 7) ? 5 : 6, 1, 0, r == 7, 0, r == 7, FRAME_1));
        vecs.push_back(mk(8'h00, 8'hAA, 1, 1, 0, 0, 0, 0, '0));
        // Row 3 too short, so the other seven rows cannot complete the frame
        vecs.push_back(mk(8'h08, 8'h33, 3, 0, 0, 0, 0, 0, '0));
        vecs.push_back(mk(8'h10, 8'h14, 6, 0, 0, 0, 0, 0, '0));
        foreach (rows_b[i])
            vecs.push_back(mk(8'(1 << rows_b[i]), 8'(8'h10 + rows_b[i]), 6, 0, 0, 0, 0, 0, '0));
        vecs.push_back(mk(8'h08, 8'h35, 5, 0, 0, 1, 0, 1, FRAME_A));
        // Second frame while A is unconsumed: overrun, A retained; then clear
        for (int r = 0; r < 8; r++)
            vecs.push_back(mk(8'(1 << r), 8'(8'h20 + r), 6, 0, 0, 1, r == 7, r == 7, FRAME_A));
        vecs.push_back(mk(8'h00, 8'h00, 1, 0, 1, 1, 0, 1, FRAME_A));
        // Frame C completes on the same edge A is consumed
        for (int r = 0; r < 7; r++)
            vecs.push_back(mk(8'(1 << r), 8'(8'h40 + r), 6, 0, 0, 1, 0, 0, '0));
        vecs.push_back(mk(8'h80, 8'h47, 4, 0, 0, 1, 0, 1, FRAME_A));
        vecs.push_back(mk(8'h80, 8'h47, 1, 1, 0, 1, 0, 1, FRAME_C));

        repeat (2) @(posedge clk_i);
        #1;
        check("reset_state", {frame_o, frame_valid_o, overrun_o, row_err_o}, '0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            row_val_i = vecs[i].row;
            col_val_i = vecs[i].col;
            frame_ready_i = vecs[i].ready;
            clear_i = vecs[i].clear;
            repeat (vecs[i].hold) step();
            check($sformatf("vec%0d_valid", i), frame_valid_o, vecs[i].exp_valid);
            check($sformatf("vec%0d_over", i), overrun_o, vecs[i].exp_over);
            if (vecs[i].chk_frame) check($sformatf("vec%0d_frame", i), frame_o, vecs[i].exp_frame);
        end
        clear_i = 1'b0;

        // Asynchronous reset mid-frame, then the pre-reset rows must be forgotten
        for (int r = 0; r < 5; r++) scan_row(r, 8'(8'h50 + r), 6, 0);
        rst_n = 1'b0;
        #1;
        check("async_reset", {frame_o, frame_valid_o, overrun_o, row_err_o}, '0);
        model_reset();
        #1;
        rst_n = 1'b1;
        for (int r = 5; r < 8; r++) scan_row(r, 8'(8'h60 + r), 6, 0);
        check("post_reset_partial", frame_valid_o, 1'b0);
        for (int r = 0; r < 5; r++) scan_row(r, 8'(8'h60 + r), 6, 0);
        check("post_reset_valid", frame_valid_o, 1'b1);
        check("post_reset_frame", frame_o, FRAME_R);

        // Multi-hot strobe for two samples gives exactly two error pulses
        err_pulses = 0;
        row_val_i = 8'b0001_0100;
        col_val_i = 8'hFF;
        repeat (2) begin step(); err_pulses += int'(row_err_o); end
        row_val_i = '0;
        repeat (4) begin step(); err_pulses += int'(row_err_o); end
        check("err_pulses", err_pulses, 2);
        check("err_no_publish", frame_o, FRAME_R);

        for (int n = 0; n < 300; n++) begin
            int unsigned kind, a, b;
            kind = $urandom_range(0, 9);
            a = $urandom_range(0, 7);
            b = (a + 1 + $urandom_range(0, 6)) % 8;
            if (kind == 0) row_val_i = '0;
            else if (kind == 1) row_val_i = 8'((1 << a) | (1 << b));
            else row_val_i = 8'(1 << a);
            col_val_i = 8'($urandom);
            frame_ready_i = 1'($urandom_range(0, 1));
            clear_i = ($urandom_range(0, 24) == 0);
            step();
            clear_i = 1'b0;
            repeat ($urandom_range(0, 6)) step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
